// File: rtl/mem_responder_if.sv
// CPU-side request/response bundle for mem_responder.
// master = CPU driving requests, slave = the responder.
interface mem_responder_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              read_mem;
  logic              write_mem;
  logic [ADDR_W-1:0] pc_wadrs;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] instruction_fetch;
  logic              fetch_valid;
  logic              stall;
  logic              wr_overflow;

  modport slave (
    input  read_mem, write_mem, pc_wadrs, result,
    output instruction_fetch, fetch_valid, stall, wr_overflow
  );

  modport master (
    output read_mem, write_mem, pc_wadrs, result,
    input  instruction_fetch, fetch_valid, stall, wr_overflow
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory with a FIFO write buffer and read forwarding.
// Reads own the array port; buffered writes drain only in read-free cycles.
module mem_responder #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int PTR_W     = $clog2(WBUF_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, BUFFERED, FULL} state_e;

  logic [DATA_W-1:0] mem_q     [MEM_DEPTH];
  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] ifetch_q;
  logic              fv_q, ovf_q;

  logic              full, empty, wr_acc, drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data, rdata;
  logic [PTR_W-1:0]  idx;

  // Full/empty come from the registered state, so a drain this cycle cannot rescue a write.
  assign full   = (state_q == FULL);
  assign empty  = (state_q == IDLE);
  assign wr_acc = bus.write_mem && !full;
  assign drain  = !bus.read_mem && !empty;

  // Oldest-to-youngest scan so the youngest match wins; a same-cycle write beats all.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < cnt_q) && (wb_addr_q[idx] == bus.pc_wadrs)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[idx];
      end
    end
    if (wr_acc) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.result;
    end
  end

  assign rdata = fwd_hit ? fwd_data : mem_q[bus.pc_wadrs];

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    case ({wr_acc, drain})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d == '0)                      state_d = IDLE;
    else if (cnt_d == CNT_W'(WBUF_DEPTH)) state_d = FULL;
    else                                  state_d = BUFFERED;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ifetch_q <= '0;
      fv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= bus.read_mem;
      if (wr_acc)        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (drain)         rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (bus.read_mem)  ifetch_q <= rdata;
      if (bus.write_mem && full) ovf_q <= 1'b1;
    end
  end

  // Storage is never cleared; reset only blocks updates.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      wb_addr_q[wr_ptr_q] <= bus.pc_wadrs;
      wb_data_q[wr_ptr_q] <= bus.result;
    end
    if (reset && drain) mem_q[wb_addr_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
  end

  assign bus.instruction_fetch = ifetch_q;
  assign bus.fetch_valid       = fv_q;
  assign bus.stall             = full;
  assign bus.wr_overflow       = ovf_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_mem_responder;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int WB = 4;

  logic clk;
  logic reset;
  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(WB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] mem_m [1 << AW];
  bit            known [1 << AW];
  logic [DW-1:0] e_if;
  bit            e_fv, e_ovf, e_known;
  int            n_vec, n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus, advances the model, then checks after the edge.
  task automatic step(input bit rst_n, input bit rd, input bit wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit            full, rk;
    logic [DW-1:0] rdat;
    ent_t          ent;
    reset         = rst_n;
    bus.read_mem  = rd;
    bus.write_mem = wr;
    bus.pc_wadrs  = a;
    bus.result    = d;
    if (!rst_n) begin
      q.delete();
      e_if = '0; e_fv = 0; e_ovf = 0; e_known = 1;
    end else begin
      full = (q.size() == WB);
      rdat = mem_m[a];
      rk   = known[a];
      foreach (q[i]) if (q[i].a == a) begin rdat = q[i].d; rk = 1; end
      if (wr && !full) begin rdat = d; rk = 1; end
      if (rd) begin e_if = rdat; e_known = rk; end
      e_fv = rd;
      if (!rd && q.size() > 0) begin
        ent = q.pop_front();
        mem_m[ent.a] = ent.d;
        known[ent.a] = 1;
      end
      if (wr) begin
        if (!full) q.push_back('{a: a, d: d});
        else       e_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, e_fv});
    chk("stall", {31'b0, bus.stall}, {31'b0, q.size() == WB});
    chk("wr_overflow", {31'b0, bus.wr_overflow}, {31'b0, e_ovf});
    if (e_known) chk("instruction_fetch", bus.instruction_fetch, e_if);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    n_vec = 0; n_err = 0;
    foreach (known[i]) known[i] = 0;
    foreach (mem_m[i]) mem_m[i] = '0;
    e_if = '0; e_fv = 0; e_ovf = 0; e_known = 1;

    step(0, 1, 1, 11'h001, 32'h12345678);
    step(0, 0, 0, '0, '0);
    chk("rst_ifetch", bus.instruction_fetch, 32'h0);

    // Write, drain, read back
    step(1, 0, 1, 11'h010, 32'hDEADBEEF);
    idle(2);
    step(1, 1, 0, 11'h010, '0);
    chk("r29_data", bus.instruction_fetch, 32'hDEADBEEF);
    chk("r29_fv", {31'b0, bus.fetch_valid}, 32'd1);
    idle(1);
    chk("r29_pulse", {31'b0, bus.fetch_valid}, 32'd0);

    // Forwarding with drain blocked by reads
    step(1, 1, 1, 11'h005, 32'h11111111);
    chk("r30_a", bus.instruction_fetch, 32'h11111111);
    step(1, 1, 1, 11'h005, 32'h22222222);
    chk("r30_b", bus.instruction_fetch, 32'h22222222);
    step(1, 1, 0, 11'h005, '0);
    chk("r30_c", bus.instruction_fetch, 32'h22222222);
    idle(3);

    // Fill, overflow, drain
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, AW'(32'h20 + i), 32'hA000_0000 + i);
      if (i == 3) chk("r31_stall", {31'b0, bus.stall}, 32'd1);
    end
    chk("r31_ovf", {31'b0, bus.wr_overflow}, 32'd1);
    idle(1);
    chk("r32_stall_drop", {31'b0, bus.stall}, 32'd0);
    idle(3);
    chk("r31_ovf_sticky", {31'b0, bus.wr_overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, AW'(32'h20 + i), '0);
      chk("r32_read", bus.instruction_fetch, 32'hA000_0000 + i);
    end

    // Reset discards buffered writes
    step(1, 0, 1, 11'h030, 32'h0000_0030);
    step(1, 0, 1, 11'h031, 32'h0000_0031);
    idle(2);
    step(1, 1, 1, 11'h030, 32'hBAD0_0030);
    step(1, 1, 1, 11'h031, 32'hBAD0_0031);
    step(0, 0, 0, '0, '0);
    step(1, 1, 0, 11'h030, '0);
    chk("r33_a", bus.instruction_fetch, 32'h0000_0030);
    step(1, 1, 0, 11'h031, '0);
    chk("r33_b", bus.instruction_fetch, 32'h0000_0031);
    chk("r33_ovf", {31'b0, bus.wr_overflow}, 32'd0);

    step(1, 1, 1, 11'h7FF, 32'hCAFEF00D);
    chk("r34", bus.instruction_fetch, 32'hCAFEF00D);

    // Random traffic on a small address pool to force frequent forwarding hits
    for (int n = 0; n < 3000; n++) begin
      ra = AW'($urandom_range(0, 8));
      if (ra == AW'(8)) ra = 11'h7FF;
      step($urandom_range(0, 99) >= 1, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 45, ra, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL be the word-address width; memory depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SHALL be the data word width.
REQ-003 Parameter WBUF_DEPTH, default 4, SHALL be the number of write-buffer entries (power of two, >=2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 read_mem  input  1  SHALL be the read request from the CPU, valid this cycle.
REQ-007 write_mem  input  1  SHALL be the write request from the CPU, valid this cycle.
REQ-008 pc_wadrs  input  ADDR_W  SHALL be the word address for the read or write.
REQ-009 result  input  DATA_W  SHALL be the write data, used only when write_mem=1.
REQ-010 instruction_fetch  output  DATA_W  SHALL be the registered read data returned to the CPU.
REQ-011 fetch_valid  output  1  SHALL be a one-cycle pulse marking new instruction_fetch data.
REQ-012 stall  output  1  SHALL be high while the write buffer is full.
REQ-013 wr_overflow  output  1  SHALL be a sticky flag set when a write is dropped.

Function
REQ-014 Storage SHALL be a single-port array of 2**ADDR_W x DATA_W; one array access (read or drain-write) per cycle.
REQ-015 A read (read_mem=1) SHALL have 1-cycle latency: instruction_fetch and fetch_valid=1 update on the edge after the request.
REQ-016 When no read is returned, fetch_valid SHALL be 0 and instruction_fetch SHALL hold its last value.
REQ-017 A write (write_mem=1, buffer not full) SHALL be enqueued into a FIFO write buffer {address, data}, never written to the array directly.
REQ-018 Full/empty SHALL be evaluated from state at the start of the cycle; a write while full SHALL be dropped and set wr_overflow, even if a drain occurs that cycle.
REQ-019 Array port arbitration: a read SHALL own the port; the buffer SHALL drain its oldest entry to the array only in cycles with read_mem=0 and buffer non-empty.
REQ-020 Enqueue and drain in the same cycle SHALL both occur; occupancy is unchanged.
REQ-021 Read forwarding: read data SHALL be the youngest buffered entry whose address matches pc_wadrs, otherwise array data.
REQ-022 Same-cycle read and accepted write to the same address SHALL return the new write data (write ordered before read).
REQ-023 Control FSM SHALL have states IDLE (buffer empty), BUFFERED (1..WBUF_DEPTH-1 entries), FULL (WBUF_DEPTH entries); transitions follow occupancy after each edge's enqueue/drain.
REQ-024 stall SHALL equal (state==FULL); occupancy counter SHALL be width log2(WBUF_DEPTH)+1 and never wrap; FIFO pointers wrap modulo WBUF_DEPTH.
REQ-025 Address and data SHALL be used unsigned, no truncation or extension; out-of-range addresses cannot occur given ADDR_W.

Reset
REQ-026 With reset=0 at an edge: instruction_fetch=0, fetch_valid=0, stall=0, wr_overflow=0, FIFO empty, state=IDLE.
REQ-027 Reset mid-operation SHALL discard all buffered, undrained writes and any pending read return; array contents SHALL NOT be cleared.
REQ-028 Requests presented while reset=0 SHALL be ignored.

Verification
REQ-029 Write 0xDEADBEEF @0x010, idle 2 cycles, read @0x010 -> next cycle instruction_fetch=0xDEADBEEF, fetch_valid=1 for exactly one cycle.
REQ-030 Write 0x11111111 then 0x22222222 @0x005 on consecutive cycles with read_mem=1 held @0x005 (blocking drain) -> reads return 0x11111111 then 0x22222222 via forwarding.
REQ-031 Five back-to-back writes with read_mem=1 held -> stall=1 after the 4th; 5th dropped, wr_overflow=1 and stays 1 until reset.
REQ-032 Full buffer, read_mem=0 for 4 cycles -> one drain per cycle, stall drops after first drain, state IDLE after 4th; subsequent reads return all 4 values.
REQ-033 Two writes buffered (reads blocking drain), assert reset=0 one cycle, then read those addresses -> previous array values returned, stall=0, wr_overflow=0.
REQ-034 Same-cycle read+write @0x7FF data 0xCAFEF00D -> next cycle instruction_fetch=0xCAFEF00D.
